// File: rtl/mem_responder_if.sv
// CPU-to-memory request/response bundle for the multi-cycle core, plus the board LED/switch pins.
// The slave side is the memory responder; the master side is the CPU controller or bench.
interface mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemFault;
  logic [7:0]  led;
  logic [7:0]  switch;

  modport master (
    output MemRead, MemWrite, Address, WriteData, switch,
    input  ReadData, MemReady, MemFault, led
  );

  modport slave (
    input  MemRead, MemWrite, Address, WriteData, switch,
    output ReadData, MemReady, MemFault, led
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM plus LED/switch MMIO behind a request/MemReady handshake.
// MemReady pulses WAIT_CYCLES+1 cycles after acceptance; requests outside IDLE are ignored.
module mem_responder #(
  parameter int          DEPTH_LOG2  = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h4000_0000
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [32:0] RAM_BYTES = 33'd4 << DEPTH_LOG2;
  localparam logic [31:0] SW_ADDR   = MMIO_BASE + 32'd4;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdat_q, wdat_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  fault_q, fault_d;
  logic [7:0]            led_q, led_d;
  logic [31:0]           mem_q [2**DEPTH_LOG2];

  logic                  accept, commit, mem_we;
  logic [31:0]           cur_addr, cur_wdat;
  logic                  cur_rd, cur_wr;
  logic                  ram_hit, led_hit, sw_hit, bad_acc;
  logic [DEPTH_LOG2-1:0] idx;

  assign accept = (state_q == S_IDLE) && (bus.MemRead || bus.MemWrite);
  assign commit = ((state_q == S_WAIT) && (cnt_q == 4'd0)) ||
                  (accept && (WAIT_CYCLES == 0));

  // With zero wait states the commit edge is the acceptance edge, so decode the live request.
  assign cur_addr = (state_q == S_IDLE) ? bus.Address   : addr_q;
  assign cur_wdat = (state_q == S_IDLE) ? bus.WriteData : wdat_q;
  assign cur_rd   = (state_q == S_IDLE) ? bus.MemRead   : rd_q;
  assign cur_wr   = (state_q == S_IDLE) ? bus.MemWrite  : wr_q;

  assign idx     = cur_addr[DEPTH_LOG2+1:2];
  assign ram_hit = {1'b0, cur_addr} < RAM_BYTES;
  assign led_hit = cur_addr == MMIO_BASE;
  assign sw_hit  = cur_addr == SW_ADDR;
  assign bad_acc = (cur_addr[1:0] != 2'b00) || !(ram_hit || led_hit || sw_hit) ||
                   (cur_wr && sw_hit) || (cur_rd && cur_wr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = accept ? bus.Address   : addr_q;
    wdat_d  = accept ? bus.WriteData : wdat_q;
    rd_d    = accept ? bus.MemRead   : rd_q;
    wr_d    = accept ? bus.MemWrite  : wr_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    led_d   = led_q;
    mem_we  = 1'b0;
    if (commit) begin
      if (bad_acc) begin
        rdata_d = '0;
        fault_d = 1'b1;
      end else if (cur_wr) begin
        if (ram_hit) mem_we = reset;
        else         led_d  = cur_wdat[7:0];
      end else begin
        if (ram_hit)      rdata_d = mem_q[idx];
        else if (led_hit) rdata_d = {24'b0, led_q};
        else              rdata_d = {24'b0, bus.switch};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdat_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      led_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      led_q   <= led_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= cur_wdat;
  end

  always_comb begin
    bus.MemReady = (state_q == S_RESP);
    bus.MemFault = fault_q;
    bus.ReadData = rdata_q;
    bus.led      = led_q;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized check of mem_responder (WAIT_CYCLES=2 and a WAIT_CYCLES=0 build) against a RAM/LED model.
module tb_mem_responder;
  localparam int          W    = 2;
  localparam int          NW   = 256;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd_i [2];
  logic        wr_i [2];
  logic [31:0] a_i, d_i;
  logic [7:0]  sw_i;
  logic        sel;

  always #5 clk = ~clk;

  mem_responder_if bus();
  mem_responder_if bus0();

  assign bus.MemRead    = rd_i[0];
  assign bus.MemWrite   = wr_i[0];
  assign bus.Address    = a_i;
  assign bus.WriteData  = d_i;
  assign bus.switch     = sw_i;
  assign bus0.MemRead   = rd_i[1];
  assign bus0.MemWrite  = wr_i[1];
  assign bus0.Address   = a_i;
  assign bus0.WriteData = d_i;
  assign bus0.switch    = sw_i;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0), .MMIO_BASE(BASE)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  logic        cur_rdy, cur_flt;
  logic [31:0] cur_rdat;
  logic [7:0]  cur_led;
  assign cur_rdy  = sel ? bus0.MemReady : bus.MemReady;
  assign cur_flt  = sel ? bus0.MemFault : bus.MemFault;
  assign cur_rdat = sel ? bus0.ReadData : bus.ReadData;
  assign cur_led  = sel ? bus0.led      : bus.led;

  int          total = 0;
  int          bad = 0;
  logic [31:0] ref_mem [2][NW];
  logic [31:0] exp_rd  [2];
  logic [7:0]  exp_led [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1ns after a rising edge with the selected DUT idle; returns the same way.
  task automatic access(input int s, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
    logic in_ram, led_hit, sw_hit, flt;
    int   n;
    in_ram  = a < 32'(4 * NW);
    led_hit = a == BASE;
    sw_hit  = a == BASE + 32'd4;
    flt = (a[1:0] != 2'b00) || !(in_ram || led_hit || sw_hit) || (wr && sw_hit) || (rd && wr);
    if (flt)          exp_rd[s] = '0;
    else if (wr) begin
      if (in_ram) ref_mem[s][a[9:2]] = d;
      else        exp_led[s] = d[7:0];
    end else if (in_ram)  exp_rd[s] = ref_mem[s][a[9:2]];
    else if (led_hit)     exp_rd[s] = {24'b0, exp_led[s]};
    else                  exp_rd[s] = {24'b0, sw_i};

    sel = (s != 0);
    a_i = a;
    d_i = d;
    rd_i[s] = rd;
    wr_i[s] = wr;
    @(posedge clk);
    #1;
    n = 1;
    while (!cur_rdy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    rd_i[s] = 1'b0;
    wr_i[s] = 1'b0;
    chk("latency", 32'(n), (s == 0) ? 32'(W + 1) : 32'd1);
    chk("fault", {31'b0, cur_flt}, {31'b0, flt});
    chk("rdata", cur_rdat, exp_rd[s]);
    chk("led", {24'b0, cur_led}, {24'b0, exp_led[s]});
    @(posedge clk);
    #1;
    chk("rdy_drop", {31'b0, cur_rdy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int          kind, op, pulses, consec, seen;
    logic        prev;
    rd_i[0] = 1'b0; wr_i[0] = 1'b0; rd_i[1] = 1'b0; wr_i[1] = 1'b0;
    a_i = '0; d_i = '0; sw_i = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", {31'b0, bus.MemReady}, 32'd0);
    chk("rst_flt", {31'b0, bus.MemFault}, 32'd0);
    chk("rst_rdat", bus.ReadData, 32'd0);
    chk("rst_led", {24'b0, bus.led}, 32'd0);
    chk("rst_rdat0", bus0.ReadData, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      exp_rd[s]  = '0;
      exp_led[s] = '0;
      for (int i = 0; i < NW; i++) ref_mem[s][i] = '0;
    end

    for (int i = 0; i < NW; i++) access(0, 1'b0, 1'b1, 32'(i * 4), 32'd0);

    access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b0, 32'h10, 32'd0);
    access(0, 1'b0, 1'b1, BASE, 32'h0000_01A5);
    sw_i = 8'h3C;
    access(0, 1'b1, 1'b0, BASE + 32'd4, 32'd0);
    access(0, 1'b1, 1'b0, 32'h12, 32'd0);
    access(0, 1'b0, 1'b1, 32'h0, 32'h1111_1111);
    access(0, 1'b0, 1'b1, 32'h400, 32'h2222_2222);
    access(0, 1'b1, 1'b0, 32'h0, 32'd0);
    access(0, 1'b1, 1'b1, 32'h8, 32'h3333_3333);
    access(0, 1'b0, 1'b1, BASE + 32'd4, 32'h0000_00FF);
    access(0, 1'b1, 1'b0, BASE, 32'd0);

    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 5);
      op   = $urandom_range(0, 9);
      sw_i = 8'($urandom);
      case (kind)
        0, 1:    a = 32'($urandom_range(0, NW - 1)) << 2;
        2:       a = (32'($urandom_range(0, NW - 1)) << 2) | 32'($urandom_range(1, 3));
        3:       a = BASE;
        4:       a = BASE + 32'd4;
        default: a = $urandom;
      endcase
      access(0, op < 5 || op == 9, op >= 5, a, $urandom);
    end

    // Request held high: one accept every W+2 edges while it stays up.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    a_i = 32'h10;
    rd_i[0] = 1'b1;
    pulses = 0;
    consec = 0;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (bus.MemReady) begin
        pulses++;
        if (prev) consec++;
        chk("held_rdat", bus.ReadData, ref_mem[0][4]);
      end
      prev = bus.MemReady;
      if (i == 9) rd_i[0] = 1'b0;
    end
    exp_rd[0] = ref_mem[0][4];
    chk("held_cnt", 32'(pulses), 32'(9 / (W + 2) + 1));
    chk("held_consec", 32'(consec), 32'd0);
    @(posedge clk);
    #1;

    access(0, 1'b0, 1'b1, 32'h20, 32'd0);
    a_i = 32'h20;
    d_i = 32'h1234_5678;
    wr_i[0] = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_i[0] = 1'b0;
    #2;
    chk("abort_led", {24'b0, bus.led}, 32'd0);
    chk("abort_rdat", bus.ReadData, 32'd0);
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      exp_rd[s]  = '0;
      exp_led[s] = '0;
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.MemReady) seen++;
    end
    chk("abort_rdy", 32'(seen), 32'd0);
    access(0, 1'b1, 1'b0, 32'h20, 32'd0);

    access(1, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
    access(1, 1'b1, 1'b0, 32'h10, 32'd0);
    access(1, 1'b0, 1'b1, BASE, 32'h0000_005A);
    access(1, 1'b1, 1'b0, 32'h12, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
